// File: rtl/mbt_worker_if.sv
// Pixel handshake and frame-memory write bus between the Mandelbrot
// controller (master) and one worker (slave).
interface mbt_worker_if;
  logic        start;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic        rst_mbt;
  logic        mbt_response;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output start, i_x, i_y, rst_mbt,
    input  mbt_response, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, i_x, i_y, rst_mbt,
    output mbt_response, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/mbt_worker.sv
// Mandelbrot worker: escape counts for 4 adjacent pixels in Q4.12, packed into one word.
// Optional debug ports DBG_worker_state / DBG_iter_cnt under `MBT_WORKER_DBG_EN.
module mbt_worker #(
  parameter int MAX_ITER = 64,
  parameter int H_RES    = 800,
  parameter int X_MIN    = -10240,
  parameter int X_STEP   = 18,
  parameter int Y_MIN    = -4915,
  parameter int Y_STEP   = 16
) (
  input  logic        clk,
  input  logic        rst,
  mbt_worker_if.slave bus
`ifdef MBT_WORKER_DBG_EN
  ,
  output logic [2:0]  DBG_worker_state,
  output logic [7:0]  DBG_iter_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [15:0]        x0_r, y0_r;
  logic [1:0]         k_r;
  logic [7:0]         cnt_r;
  logic signed [15:0] zr_r, zi_r, c_re_r, c_im_r;
  logic [23:0]        pix_r;
  logic               wr_en_r, mbt_response_r;
  logic [16:0]        wr_addr_r;
  logic [31:0]        wr_data_r;

  logic signed [31:0] zr2_s, zi2_s, zrzi_s;
  logic signed [32:0] mag_s, re_s, im_s;
  logic [15:0]        zr_nx_s, zi_nx_s, c_re_s, c_im_s;
  logic [16:0]        addr_s;
  logic               escape_s;

  // Iteration datapath and per-pixel constants
  always_comb begin
    zr2_s    = zr_r * zr_r;
    zi2_s    = zi_r * zi_r;
    zrzi_s   = zr_r * zi_r;
    mag_s    = $signed({zr2_s[31], zr2_s}) + $signed({zi2_s[31], zi2_s});
    re_s     = $signed({zr2_s[31], zr2_s}) - $signed({zi2_s[31], zi2_s});
    im_s     = $signed({zrzi_s, 1'b0});
    zr_nx_s  = 16'(re_s >>> 12) + c_re_r;
    zi_nx_s  = 16'(im_s >>> 12) + c_im_r;
    escape_s = (mag_s > 33'sd67108864) || (cnt_r == 8'(MAX_ITER));
    // x0 is a multiple of 4, so x0+k is formed modulo 2^16 like the result
    c_re_s   = 16'(X_MIN) + (x0_r + {14'd0, k_r}) * 16'(X_STEP);
    c_im_s   = 16'(Y_MIN) + y0_r * 16'(Y_STEP);
    addr_s   = 17'(y0_r) * 17'(H_RES / 4) + {3'd0, x0_r[15:2]};
  end

  // Next-state logic; a controller clear always wins over progress
  always_comb begin
    state_s = state_r;
    if (bus.rst_mbt) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) state_s = LOAD;
          else           state_s = IDLE;
        end
        LOAD:  state_s = ITER;
        ITER: begin
          if (escape_s) begin
            if (k_r == 2'd3) state_s = WRITE;
            else             state_s = LOAD;
          end else begin
            state_s = ITER;
          end
        end
        WRITE:   state_s = RESP;
        RESP:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Group capture, per-pixel iteration and count packing
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_r   <= 16'd0;
      y0_r   <= 16'd0;
      k_r    <= 2'd0;
      cnt_r  <= 8'd0;
      zr_r   <= 16'sd0;
      zi_r   <= 16'sd0;
      c_re_r <= 16'sd0;
      c_im_r <= 16'sd0;
      pix_r  <= 24'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.rst_mbt) begin
            x0_r <= bus.i_x;
            y0_r <= bus.i_y;
            k_r  <= 2'd0;
          end
        end
        LOAD: begin
          c_re_r <= c_re_s;
          c_im_r <= c_im_s;
          zr_r   <= 16'sd0;
          zi_r   <= 16'sd0;
          cnt_r  <= 8'd0;
        end
        ITER: begin
          if (escape_s) begin
            case (k_r)
              2'd0:    pix_r[7:0]   <= cnt_r;
              2'd1:    pix_r[15:8]  <= cnt_r;
              2'd2:    pix_r[23:16] <= cnt_r;
              default: pix_r        <= pix_r;
            endcase
            k_r <= k_r + 2'd1;
          end else begin
            zr_r  <= zr_nx_s;
            zi_r  <= zi_nx_s;
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered handshake outputs; pixel 3's count goes straight into the word
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_r        <= 1'b0;
      mbt_response_r <= 1'b0;
      wr_addr_r      <= 17'd0;
      wr_data_r      <= 32'd0;
    end else begin
      wr_en_r        <= (state_s == WRITE);
      mbt_response_r <= (state_s == RESP);
      if (state_s == WRITE) begin
        wr_addr_r <= addr_s;
        wr_data_r <= {cnt_r, pix_r};
      end
    end
  end

  assign bus.wr_en        = wr_en_r;
  assign bus.mbt_response = mbt_response_r;
  assign bus.wr_addr      = wr_addr_r;
  assign bus.wr_data      = wr_data_r;

`ifdef MBT_WORKER_DBG_EN
  assign DBG_worker_state = state_r;
  assign DBG_iter_cnt     = cnt_r;
`endif

endmodule

// File: doc/mbt_worker.md
# mbt_worker

Responder side of the Mandelbrot pixel handshake. Accepts a one-cycle `start` with a group origin (`i_x`, `i_y`) from the pixel controller. Computes the escape-iteration count of 4 horizontally adjacent pixels (`i_x` .. `i_x+3`) in Q4.12 fixed point, one iteration per cycle. Writes the packed counts to frame memory, then returns a one-cycle `mbt_response`.

## Interface
- `MAX_ITER`, 64: iteration cap, 1..255.
- `H_RES`, 800: horizontal resolution, multiple of 4.
- `X_MIN`, -10240: signed Q4.12 real part at x=0 (-2.5).
- `X_STEP`, 18: signed Q4.12 real increment per pixel.
- `Y_MIN`, -4915: signed Q4.12 imaginary part at y=0 (-1.2).
- `Y_STEP`, 16: signed Q4.12 imaginary increment per line.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rst_mbt`  in  1  soft clear from controller, synchronous, active-high.
- `start`  in  1  request strobe, one cycle; `i_x`/`i_y` valid in the same cycle.
- `i_x`  in  16  first pixel column of group, multiple of 4.
- `i_y`  in  16  pixel row.
- `mbt_response`  out  1  group-done pulse, registered.
- `wr_en`  out  1  frame-memory write strobe, registered.
- `wr_addr`  out  17  word address = `i_y`*(`H_RES`/4) + `i_x`>>2.
- `wr_data`  out  32  pixel k count in bits [8k+7:8k].

## Operation
- FSM states: IDLE, LOAD, ITER, WRITE, RESP (3-bit encoding).
- Control priority: `rst` > `rst_mbt` > `start`.
- IDLE -> LOAD when `start`=1 and `rst_mbt`=0. On that edge, capture `i_x`/`i_y` and set pixel index k=0.
- LOAD (1 cycle):
  - c_re = X_MIN + (x0+k)*X_STEP.
  - c_im = Y_MIN + y0*Y_STEP.
  - Both truncated mod 2^16, signed.
  - zr=zi=0, cnt=0. Go to ITER.
- ITER (1 cycle per step):
  - Products zr², zi², zr*zi are 32-bit signed (Q8.24).
  - mag = zr²+zi², 33-bit.
  - If mag > 2^26 (4.0) or cnt==MAX_ITER: store cnt into byte k. Then go to LOAD with k+1 if k<3, else go to WRITE.
  - Otherwise: zr <= ((zr²-zi²)>>>12)+c_re; zi <= ((2*zr*zi)>>>12)+c_im; both truncated to 16 bits; cnt+1.
  - The escape check precedes the update, so |z|≤2 and no overflow occurs on any stored z for the default window.
- WRITE (1 cycle): `wr_en`=1, `wr_addr`/`wr_data` valid. Next state RESP.
- RESP (1 cycle): `mbt_response`=1. Next state IDLE.
- `start` outside IDLE is ignored.
- `rst_mbt` in any state: return to IDLE next cycle. No `wr_en` and no `mbt_response` issued for an aborted group. Captured data is don't-care.
- The controller asserts `rst_mbt` while `mbt_response` is high. That cycle's clear lands in IDLE, matching the normal RESP exit; the pulse is already out.
- A held `rst_mbt` keeps the block in IDLE; `start` is ignored while it is high.

## Timing
- Reset values: `mbt_response`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, state IDLE.
- Cycle 0 = `start` sampled.
- Pixel k occupies 2+cnt_k cycles (LOAD + cnt_k+1 ITER).
- `wr_en` is high in cycle 1+Σ(2+cnt_k), for exactly 1 cycle.
- `mbt_response` is high in the next cycle, for exactly 1 cycle.
- `wr_en` and `mbt_response` are never high together.
- Worst case: 4*(2+MAX_ITER)+2 cycles per group.
- Next `start` is accepted one cycle after RESP at the earliest, i.e. in IDLE.
- `wr_addr`/`wr_data` hold their values after WRITE until the next WRITE.

## Configuration
- `MBT_WORKER_DBG_EN` defined:
  - Adds output `DBG_worker_state` [2:0]: IDLE=0, LOAD=1, ITER=2, WRITE=3, RESP=4.
  - Adds output `DBG_iter_cnt` [7:0], mirroring cnt.
  - Both reset to 0.
- Undefined: those ports and their logic are absent. Functional behaviour and timing are identical.

## Test plan
- Corner group: `start` with x=0, y=0. Every pixel escapes at cnt=1. Required: `wr_en` in cycle 13 with `wr_addr`=0, `wr_data`=0x01010101; `mbt_response` in cycle 14.
- In-set group: x=456, y=307 (c≈-0.49+0i, main cardioid). Required: `wr_data`=0x40404040, `wr_addr`=61514, `wr_en` in cycle 265, `mbt_response` in cycle 266.
- Abort: `rst_mbt` pulsed in cycle 100 of the in-set group. Required: state is IDLE in cycle 101, and `wr_en`/`mbt_response` never assert. A following corner `start` completes normally in 14 cycles.
- Busy start: extra `start` pulses during ITER of a corner group. Required: ignored; exactly one `wr_en` and one `mbt_response`.
- Controller loop: drive with the pixel controller for rows 0..1 and `rst_mbt` = response | finished. Required: 400 writes at addresses 0..399 in order, each followed by one response, with no lost or duplicated group.
- Reset: `rst` mid-ITER. Required: all outputs 0 next cycle, state IDLE.
